s_mem_arbiter: RTL and testbench

- Shares the single-port 256x8 S memory between the RC4 loop engines: init, key-schedule shuffle and decrypt/keystream.
- Each engine issues single-cycle accesses over a req/gnt handshake.
- An engine can lock the memory across several accesses so that a read-read-write-write swap of S[i]/S[j] is atomic.
- Sits between the loop FSMs and the s_memory instance. It drives the memory's address, data and write enable, and fans the read data back to the requesters.

---
 rtl/rc4_pkg.sv | 24 ++
 rtl/s_mem_arbiter_rr_pick.sv | 31 +++
 rtl/s_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_s_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared constants and types for the RC4 S-memory subsystem.
//   S_ADDR_W / S_DATA_W : geometry of the 256x8 S memory
//   arb_state_t         : S-memory arbiter state encoding
//   REQ_*               : requester slot of each loop engine on the arbiter
//   idx_w()             : width of an index into an n-entry vector (min 1)
package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int REQ_INIT = 0;
    localparam int REQ_SHUF = 1;
    localparam int REQ_DEC  = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index granted last; scanning starts at rr_ptr+1
//   gnt    out NUM_REQ  one-hot pick (all zero when req is zero)
module rr_pick
    import rc4_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt
);

    // Walk from the lowest priority (rr_ptr itself) up to the highest
    // (rr_ptr+1); a later hit overrides an earlier one, so the last
    // writer is the highest-priority requester.
    always_comb begin
        gnt = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: shares the single-port S memory between the RC4 loop
// engines (init, shuffle, decrypt). Round-robin arbitration with an
// optional multi-access lock so an S[i]/S[j] swap is atomic.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   req/lock/wen          per-requester request, hold-ownership, write flag
//   addr/wdata            flattened per-requester address / write data
//   gnt                   one-hot combinational grant
//   rvalid, rdata         per-requester read-valid pulse, shared read data
//   mem_addr/wdata/wren   drive to s_memory; mem_q is its read data
//   busy                  locked or a read is in flight
//   timeout_err           sticky lock watchdog flag
//
// Optional feature: define SMEM_ARB_WATCHDOG_EN to enable the lock
// watchdog (LOCK_TIMEOUT idle locked cycles force the lock off).
module s_mem_arbiter
    import rc4_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = S_ADDR_W,
    parameter int DATA_W       = S_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        wen,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PW = idx_w(NUM_REQ);

    arb_state_t state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [PW-1:0] gidx;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] rd_push;
    logic [RD_LATENCY-1:0][NUM_REQ-1:0] vld_pipe;
    logic wd_force;   // watchdog kills the lock this cycle
    logic lock_blk;   // granted requester's lock must be ignored

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .gnt    (pick)
    );

    // While locked only the owner may be granted; gnt is never set
    // without a matching req.
    always_comb begin
        gnt = pick;
        if (state_q == ARB_LOCKED) begin
            gnt          = '0;
            gnt[owner_q] = req[owner_q];
        end
    end

    // Memory mux; gnt is one-hot so at most one slice is selected.
    always_comb begin
        gidx      = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gidx      = PW'(k);
                mem_addr  = addr[k*ADDR_W +: ADDR_W];
                mem_wdata = wdata[k*DATA_W +: DATA_W];
                mem_wren  = wen[k];
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= PW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (|gnt) begin
                    rr_d = gidx;
                    if (lock[gidx] && !lock_blk) begin
                        state_d = ARB_LOCKED;
                        owner_d = gidx;
                    end
                end
            end
            ARB_LOCKED: begin
                // The access in the releasing cycle is still granted above.
                if (!lock[owner_q] || wd_force)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // ---------------- read-valid pipeline ----------------
    assign rd_push = gnt & ~wen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_push;
            for (int i = 1; i < RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rvalid = vld_pipe[RD_LATENCY-1];
    assign rdata  = mem_q;
    assign busy   = (state_q == ARB_LOCKED) || (|vld_pipe);

    // ---------------- lock watchdog ----------------
`ifdef SMEM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_blk;
    logic [PW-1:0] wd_idx;
    logic          to_err;

    // Fires on the LOCK_TIMEOUT-th consecutive locked cycle without an
    // owner access, provided the owner is still holding lock.
    assign wd_force = (state_q == ARB_LOCKED) && lock[owner_q] &&
                      !gnt[owner_q] && (wd_cnt == CW'(LOCK_TIMEOUT - 1));
    assign lock_blk = wd_blk && (gidx == wd_idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            wd_blk <= 1'b0;
            wd_idx <= '0;
            to_err <= 1'b0;
        end else begin
            if (state_q == ARB_IDLE && state_d == ARB_LOCKED)
                wd_cnt <= '0;
            else if (state_q == ARB_LOCKED)
                wd_cnt <= gnt[owner_q] ? '0 : wd_cnt + 1'b1;

            // A timed-out owner must release lock once before it may
            // lock again; otherwise it would re-lock on its next grant.
            if (wd_force) begin
                to_err <= 1'b1;
                wd_blk <= 1'b1;
                wd_idx <= owner_q;
            end else if (wd_blk && !lock[wd_idx]) begin
                wd_blk <= 1'b0;
            end
        end
    end

    assign timeout_err = to_err;
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = |LOCK_TIMEOUT;
    assign wd_force    = 1'b0;
    assign lock_blk    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Directed bench for s_mem_arbiter. Two instances share the stimulus:
// u_dut (RD_LATENCY=1) and u_dut2 (RD_LATENCY=2), each with its own
// behavioural S memory preloaded with mem[i] = i + 0x40.
module tb_s_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0, lock = '0, wen = '0;
    logic [23:0] addr = '0, wdata = '0;
    logic        mem_load = 1'b0;

    logic [2:0] gnt1, rvalid1, gnt2, rvalid2;
    logic [7:0] rdata1, mem_addr1, mem_wdata1, mem_q1;
    logic [7:0] rdata2, mem_addr2, mem_wdata2, mem_q2;
    logic       mem_wren1, busy1, to1, mem_wren2, busy2, to2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s_mem_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .LOCK_TIMEOUT(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .wen(wen),
        .addr(addr), .wdata(wdata), .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wren(mem_wren1),
        .mem_q(mem_q1), .busy(busy1), .timeout_err(to1)
    );

    s_mem_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LATENCY(2), .LOCK_TIMEOUT(8)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .wen(wen),
        .addr(addr), .wdata(wdata), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wren(mem_wren2),
        .mem_q(mem_q2), .busy(busy2), .timeout_err(to2)
    );

    // Behavioural S memories: latency 1 and latency 2.
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] q1, q2a, q2b;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(i + 64);
        end else if (mem_wren1) begin
            mem1[mem_addr1] <= mem_wdata1;
        end
        q1 <= mem1[mem_addr1];
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem2[i] <= 8'(i + 64);
        end else if (mem_wren2) begin
            mem2[mem_addr2] <= mem_wdata2;
        end
        q2a <= mem2[mem_addr2];
        q2b <= q2a;
    end

    assign mem_q1 = q1;
    assign mem_q2 = q2b;

    task automatic do_reset(input logic load);
        @(negedge clk);
        reset_n = 1'b0;
        req = '0; lock = '0; wen = '0; addr = '0; wdata = '0;
        mem_load = load;
        repeat (2) @(negedge clk);
        mem_load = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        #1;
        checks++; if (gnt1 !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt1); end
        checks++; if (rvalid1 !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (mem_wren1 !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", mem_wren1); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", to1); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    endtask

    task automatic test_round_robin;
        logic [2:0] eg [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
        logic [2:0] ev [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
        logic [7:0] ed [5] = '{8'h00, 8'h50, 8'h60, 8'h70, 8'h50};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req  = (c < 4) ? 3'b111 : 3'b000;
            lock = '0; wen = '0;
            addr = {8'h30, 8'h20, 8'h10};
            #1;
            checks++; if (gnt1 !== eg[c]) begin errors++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt1, eg[c]); end
            checks++; if (rvalid1 !== ev[c]) begin errors++; $display("FAIL rr_rvalid c%0d: got %b expected %b", c, rvalid1, ev[c]); end
            if (ev[c] != 3'b000) begin
                checks++; if (rdata1 !== ed[c]) begin errors++; $display("FAIL rr_rdata c%0d: got %h expected %h", c, rdata1, ed[c]); end
            end
        end
    endtask

    task automatic test_lock_swap;
        logic [2:0] rq [8] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b001, 3'b000};
        logic [2:0] lk [8] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [2:0] wn [8] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [7:0] a1 [8] = '{8'h05, 8'h09, 8'h05, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] d1 [8] = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] a0 [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h09, 8'h00};
        logic [2:0] eg [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b000};
        logic [2:0] ev [8] = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
        logic [7:0] ed [8] = '{8'h00, 8'h45, 8'h49, 8'h00, 8'h00, 8'h40, 8'hAA, 8'hBB};
        logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = rq[c]; lock = lk[c]; wen = wn[c];
            addr  = {8'h00, a1[c], a0[c]};
            wdata = {8'h00, d1[c], 8'h00};
            #1;
            checks++; if (gnt1 !== eg[c]) begin errors++; $display("FAIL lock_gnt c%0d: got %b expected %b", c, gnt1, eg[c]); end
            checks++; if (rvalid1 !== ev[c]) begin errors++; $display("FAIL lock_rvalid c%0d: got %b expected %b", c, rvalid1, ev[c]); end
            if (ev[c] != 3'b000) begin
                checks++; if (rdata1 !== ed[c]) begin errors++; $display("FAIL lock_rdata c%0d: got %h expected %h", c, rdata1, ed[c]); end
            end
            checks++; if (busy1 !== eb[c]) begin errors++; $display("FAIL lock_busy c%0d: got %b expected %b", c, busy1, eb[c]); end
            checks++; if (mem_wren1 !== (wn[c][1] & eg[c][1])) begin errors++; $display("FAIL lock_wren c%0d: got %b expected %b", c, mem_wren1, wn[c][1] & eg[c][1]); end
            if (wn[c][1]) begin
                checks++; if (mem_addr1 !== a1[c] || mem_wdata1 !== d1[c]) begin errors++; $display("FAIL lock_wdrive c%0d: got %h/%h expected %h/%h", c, mem_addr1, mem_wdata1, a1[c], d1[c]); end
            end
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        req = 3'b001; lock = '0; wen = 3'b001; addr = {16'h0000, 8'hFF}; wdata = {16'h0000, 8'h7F};
        #1;
        checks++; if (gnt1 !== 3'b001) begin errors++; $display("FAIL wr_gnt: got %b expected 001", gnt1); end
        checks++; if (mem_wren1 !== 1'b1 || mem_addr1 !== 8'hFF || mem_wdata1 !== 8'h7F) begin errors++; $display("FAIL wr_drive: got %b/%h/%h expected 1/ff/7f", mem_wren1, mem_addr1, mem_wdata1); end
        @(negedge clk);
        wen = 3'b000;
        #1;
        checks++; if (mem_wren1 !== 1'b0 || gnt1 !== 3'b001) begin errors++; $display("FAIL rd_issue: got wren %b gnt %b expected 0/001", mem_wren1, gnt1); end
        @(negedge clk);
        req = 3'b000; wen = 3'b111; addr = {3{8'h33}}; wdata = {3{8'h44}};
        #1;
        checks++; if (rvalid1 !== 3'b001 || rdata1 !== 8'h7F) begin errors++; $display("FAIL wr_readback: got %b/%h expected 001/7f", rvalid1, rdata1); end
        checks++; if (mem_addr1 !== 8'h00 || mem_wdata1 !== 8'h00 || mem_wren1 !== 1'b0) begin errors++; $display("FAIL idle_drive: got %h/%h/%b expected 00/00/0", mem_addr1, mem_wdata1, mem_wren1); end
    endtask

    task automatic test_reset_locked;
        @(negedge clk);
        req = 3'b100; lock = 3'b100; wen = '0; addr = {8'h10, 16'h0000}; wdata = '0;
        #1;
        checks++; if (gnt1 !== 3'b100) begin errors++; $display("FAIL rl_gnt0: got %b expected 100", gnt1); end
        @(negedge clk);
        req = 3'b101;
        #1;
        checks++; if (gnt1 !== 3'b100 || busy1 !== 1'b1) begin errors++; $display("FAIL rl_locked: got gnt %b busy %b expected 100/1", gnt1, busy1); end
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (busy1 !== 1'b0 || rvalid1 !== 3'b000) begin errors++; $display("FAIL rl_in_reset: got busy %b rvalid %b expected 0/000", busy1, rvalid1); end
        reset_n = 1'b1;
        req = 3'b111; lock = '0; addr = {8'h30, 8'h20, 8'h10};
        #1;
        checks++; if (gnt1 !== 3'b001) begin errors++; $display("FAIL rl_prio: got %b expected 001", gnt1); end
        @(negedge clk);
        #1;
        checks++; if (rvalid1 !== 3'b001 || rdata1 !== 8'h50) begin errors++; $display("FAIL rl_rvalid: got %b/%h expected 001/50", rvalid1, rdata1); end
        req = '0;
    endtask

    task automatic test_rd_latency2;
        logic [2:0] ev [6] = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000};
        logic [7:0] ed [6] = '{8'h00, 8'h00, 8'h50, 8'h51, 8'h52, 8'h00};
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req  = (c < 3) ? 3'b100 : 3'b000;
            lock = '0; wen = '0;
            addr = {8'(8'h10 + c), 16'h0000};
            #1;
            checks++; if (gnt2 !== ((c < 3) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL rl2_gnt c%0d: got %b", c, gnt2); end
            checks++; if (rvalid2 !== ev[c]) begin errors++; $display("FAIL rl2_rvalid c%0d: got %b expected %b", c, rvalid2, ev[c]); end
            if (ev[c] != 3'b000) begin
                checks++; if (rdata2 !== ed[c]) begin errors++; $display("FAIL rl2_rdata c%0d: got %h expected %h", c, rdata2, ed[c]); end
            end
        end
    endtask

    task automatic test_watchdog;
        do_reset(1'b0);
        @(negedge clk);
        req = 3'b100; lock = 3'b100; wen = '0; addr = '0;
        #1;
        checks++; if (gnt1 !== 3'b100) begin errors++; $display("FAIL wd_lock_gnt: got %b expected 100", gnt1); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req = 3'b001;
            #1;
            checks++; if (gnt1 !== 3'b000 || busy1 !== 1'b1 || to1 !== 1'b0) begin errors++; $display("FAIL wd_hold c%0d: got gnt %b busy %b err %b expected 000/1/0", c, gnt1, busy1, to1); end
        end
        @(negedge clk);
        #1;
`ifdef SMEM_ARB_WATCHDOG_EN
        checks++; if (gnt1 !== 3'b001 || to1 !== 1'b1) begin errors++; $display("FAIL wd_fire: got gnt %b err %b expected 001/1", gnt1, to1); end
        @(negedge clk);
        req = 3'b100;
        #1;
        checks++; if (gnt1 !== 3'b100) begin errors++; $display("FAIL wd_relock_gnt: got %b expected 100", gnt1); end
        @(negedge clk);
        req = 3'b001;
        #1;
        checks++; if (gnt1 !== 3'b001 || to1 !== 1'b1) begin errors++; $display("FAIL wd_lock_ignored: got gnt %b err %b expected 001/1", gnt1, to1); end
`else
        checks++; if (gnt1 !== 3'b000 || to1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL nowd_hold: got gnt %b err %b busy %b expected 000/0/1", gnt1, to1, busy1); end
        @(negedge clk);
        lock = '0;
        #1;
        checks++; if (gnt1 !== 3'b000) begin errors++; $display("FAIL nowd_release: got %b expected 000", gnt1); end
        @(negedge clk);
        #1;
        checks++; if (gnt1 !== 3'b001 || to1 !== 1'b0) begin errors++; $display("FAIL nowd_after: got gnt %b err %b expected 001/0", gnt1, to1); end
`endif
        @(negedge clk);
        req = '0; lock = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_swap();
        test_write_read();
        test_reset_locked();
        test_rd_latency2();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
